// File: rtl/sevenseg_status_mux.sv
// N-digit multiplexed seven-segment status driver with dead-time blanking and frame-atomic updates.
// Optional per-digit blinking is compiled in when SEVSEG_BLINK_EN is defined.
module sevenseg_status_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 64,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_codes,
    input  logic [NUM_DIGITS-1:0]   upd_blink,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int MAX_LIM = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;
    localparam int DIG_W   = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic {S_DRIVE, S_BLANK} state_t;

    state_t                  state_reg;
    logic [DIG_W-1:0]        digit_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [6:0]              seg_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    frame_done_reg;
    logic                    pending_reg;
    logic [3:0]              active_codes_reg [NUM_DIGITS];
    logic [3:0]              shadow_codes_reg [NUM_DIGITS];
    logic [3:0]              upd_code_arr     [NUM_DIGITS];

    logic [DIG_W-1:0]        digit_inc;
    logic                    boundary;
    logic                    load_active;
    logic                    accept;
    logic                    blink_off;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b0100011;
            4'h2:    return 7'b0101111;
            4'h4:    return 7'b1000110;
            4'h8:    return 7'b1000111;
            4'hF:    return 7'b1111111;
            default: return 7'b0111111;
        endcase
    endfunction

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign upd_code_arr[gi] = upd_codes[4*gi +: 4];
        assign an_next[gi]      = !((state_reg == S_DRIVE) && (digit_reg == DIG_W'(gi)));
    end

    assign digit_inc   = (digit_reg == DIG_LAST) ? '0 : digit_reg + 1'b1;
    // The frame ends on the last digit's dead time, or on its drive slot when there is no dead time.
    assign boundary    = (digit_reg == DIG_LAST) &&
                         ((BLANK_CYCLES == 0) ? (state_reg == S_DRIVE && cnt_reg == DRIVE_LAST)
                                              : (state_reg == S_BLANK && cnt_reg == BLANK_LAST));
    assign load_active = boundary && pending_reg;
    assign accept      = upd_valid && !pending_reg;
    assign seg_next    = (state_reg == S_DRIVE && !blink_off) ? glyph(active_codes_reg[digit_reg])
                                                               : 7'b1111111;

    assign upd_ready  = !pending_reg;
    assign seg        = seg_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_DRIVE;
            digit_reg      <= '0;
            cnt_reg        <= '0;
            seg_reg        <= 7'b1111111;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            seg_reg        <= seg_next;
            an_reg         <= an_next;
            frame_done_reg <= boundary;
            case (state_reg)
                S_DRIVE: begin
                    if (cnt_reg == DRIVE_LAST) begin
                        cnt_reg <= '0;
                        if (BLANK_CYCLES == 0) digit_reg <= digit_inc;
                        else                   state_reg <= S_BLANK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= S_DRIVE;
                        digit_reg <= digit_inc;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= S_DRIVE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_codes_reg[i] <= 4'hF;
                shadow_codes_reg[i] <= 4'hF;
            end
        end else if (load_active) begin
            active_codes_reg <= shadow_codes_reg;
            pending_reg      <= 1'b0;
        end else if (accept) begin
            shadow_codes_reg <= upd_code_arr;
            pending_reg      <= 1'b1;
        end
    end

`ifdef SEVSEG_BLINK_EN
    localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

    logic [FR_W-1:0]       frame_cnt_reg;
    logic                  blink_phase_reg;
    logic [NUM_DIGITS-1:0] active_blink_reg;
    logic [NUM_DIGITS-1:0] shadow_blink_reg;

    assign blink_off = blink_phase_reg && active_blink_reg[digit_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg    <= '0;
            blink_phase_reg  <= 1'b0;
            active_blink_reg <= '0;
            shadow_blink_reg <= '0;
        end else begin
            if (boundary) begin
                if (frame_cnt_reg == FR_LAST) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= !blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
            if (load_active)  active_blink_reg <= shadow_blink_reg;
            else if (accept)  shadow_blink_reg <= upd_blink;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^upd_blink;
    assign blink_off    = 1'b0;
`endif

endmodule

// File: doc/sevenseg_status_mux.md
# sevenseg_status_mux

Parametrised N-digit multiplexed seven-segment status display driver. It sits between the robot status logic and the board's common-anode display, and shows one status glyph per digit: L, C, r, o, 0, dash or blank. It replaces the fixed 4-digit display with configurable:
- digit count;
- refresh rate;
- anti-ghosting dead time;
- frame-atomic updates through a valid/ready handshake;
- optional per-digit blinking.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- REFRESH_DIV, 100000: clocks each digit is driven per slot (≥1).
- BLANK_CYCLES, 64: dead-time clocks between digit slots, with all anodes off (0 = no dead time).
- BLINK_FRAMES, 32: frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- upd_valid  in  1  new display contents offered.
- upd_ready  out  1  shadow register free; an update is accepted when upd_valid && upd_ready.
- upd_codes  in  4*NUM_DIGITS  per-digit 4-bit code; digit i is bits [4i+3:4i].
- upd_blink  in  NUM_DIGITS  per-digit blink enable.
- seg  out  7  segment drive {g..a}, active-low.
- an  out  NUM_DIGITS  anode select, active-low; an[i] drives digit i.
- frame_done  out  1  one-cycle pulse at every frame boundary.

## Operation
- Glyph decode, active-low:
  - 0x0 → 1000000 ("0", idle).
  - 0x1 → 0100011 ("o", overcurrent).
  - 0x2 → 0101111 ("r", right).
  - 0x4 → 1000110 ("C", centre).
  - 0x8 → 1000111 ("L", left).
  - 0xF → 1111111 (blank).
  - Every other code → 0111111 (dash).
- State machine, two states:
  - DRIVE: an has a single 0 at the current digit; seg shows that digit's glyph. Lasts REFRESH_DIV cycles.
  - BLANK: an = all 1s, seg = 1111111. Lasts BLANK_CYCLES cycles. Skipped entirely when BLANK_CYCLES = 0.
- Digit order: 0, 1, …, NUM_DIGITS-1, then wrap to 0.
- Frame boundary: the final cycle of the last digit's BLANK state, or of its DRIVE state when BLANK_CYCLES = 0. In that cycle:
  - frame_done is asserted;
  - if an update is pending, the active register loads from the shadow register and the pending flag clears.
- Handshake:
  - upd_ready = ~pending.
  - An accepted update loads the shadow register and sets pending.
  - While pending is set, upd_valid is ignored and the inputs may change freely.
  - An update accepted during a boundary cycle with pending clear is applied at the next boundary, one full frame later.
- Contents never change mid-frame; no partial-frame tearing.
- Active register reset value: all codes 0xF (blank), blink mask 0. A display is therefore dark until the first update has been applied.
- Arithmetic:
  - Slot counter is $clog2(max(REFRESH_DIV, BLANK_CYCLES)) bits wide and counts 0..limit-1.
  - Digit index is $clog2(NUM_DIGITS) bits wide and wraps explicitly at NUM_DIGITS-1, not at the power of two.

## Timing
- Frame length = NUM_DIGITS × (REFRESH_DIV + BLANK_CYCLES) clocks.
- seg and an are registered and follow internal state with one cycle of latency.
- frame_done is registered and aligned with the boundary state cycle + 1.
- Reset values: seg = 1111111, an = all 1s, frame_done = 0, upd_ready = 1, state = DRIVE, digit = 0, counters = 0, blink phase = 0.
- First rising edge after rst_n deasserts: an[0] goes low (showing blank).
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously); any pending update is discarded.

## Configuration
- SEVSEG_BLINK_EN defined:
  - A frame counter runs 0..BLINK_FRAMES-1 and toggles blink_phase when it wraps.
  - While blink_phase = 1, any digit whose active blink bit is set shows 1111111 during DRIVE; its anode is still driven.
  - Blink phase and frame counter reset to 0.
- SEVSEG_BLINK_EN undefined:
  - No frame counter exists.
  - upd_blink is accepted but ignored; no digit ever blinks.

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset release, no update → an cycles 1110 (4 clk), 1111 (2 clk), 1101, …, 0111; seg stays 1111111; frame_done pulses every 24 clk.
- Update codes 0x8421 mid-frame → upd_ready drops the next cycle. After the next frame_done: digit0 = 0100011, digit1 = 0101111, digit2 = 1000110, digit3 = 1000111. upd_ready returns to 1.
- Second upd_valid held while pending → ignored. Shadow keeps the first value and upd_ready stays 0 until the boundary.
- Code 0x5 on digit 1 → dash 0111111. Code 0x0 → 1000000.
- SEVSEG_BLINK_EN, upd_blink = 0001 → digit 0 shows its glyph for 2 frames, then 1111111 for 2 frames. Other digits are unaffected. Without the macro, digit 0 never blanks.
- rst_n pulsed low during digit 2 DRIVE with an update pending → outputs go to reset values immediately. After release, the display restarts at digit 0, blank, and the pending data is never shown.
